// File: rtl/if_stage.sv
// rtl/if_stage.sv - P5 MIPS fetch stage: PC register, next-PC select and IF/ID register
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        adel_d
);

    localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;

    logic [31:0] seq_pc;
    logic [31:0] pc_d4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;
    logic [32:0] im_off;
    logic        fetch_fault;

    always_comb begin
        seq_pc    = pc_f + 32'd4;
        pc_d4     = pc_d + 32'd4;
        br_target = pc_d4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
        j_target  = {pc_d4[31:28], index26_d, 2'b00};
        case (npc_sel)
            2'b01:   next_pc = br_taken ? br_target : seq_pc;
            2'b10:   next_pc = j_target;
            2'b11:   next_pc = jr_target;
            default: next_pc = seq_pc;
        endcase
        // 33-bit difference: addresses below IM_BASE go negative and land above the span
        im_off      = {1'b0, pc_f} - {1'b0, IM_BASE};
        fetch_fault = (pc_f[1:0] != 2'b00) || (im_off >= IM_SPAN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= PC_RESET;
        end else if (!stall) begin
            pc_f <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d <= 32'd0;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (flush) begin
            instr_d <= 32'd0;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (!stall) begin
            pc_d    <= pc_f;
            valid_d <= 1'b1;
            adel_d  <= fetch_fault;
            instr_d <= fetch_fault ? 32'd0 : instr_f;
        end
    end

endmodule
